// File: rtl/mesh_term_inject_arb.sv
// Multi-channel packet injector for one mesh terminal: per-channel circular FIFOs,
// self-address filtering, sticky overflow flags and a round-robin grant to the router.
module mesh_term_inject_arb #(
  parameter int unsigned          pckg_sz    = 40,
  parameter int unsigned          fifo_depth = 4,
  parameter int unsigned          NUM_CH     = 2,
  parameter logic [3:0]           self_row   = 4'd0,
  parameter logic [3:0]           self_col   = 4'd1,
  parameter logic [pckg_sz-19:0]  bdcst      = {(pckg_sz-18){1'b1}},
  parameter int unsigned          CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         push,
  input  logic [NUM_CH*pckg_sz-1:0] data_in,
  output logic [NUM_CH-1:0]         full,
  output logic                      pndng,
  output logic [pckg_sz-1:0]        data_out,
  input  logic                      pop,
  output logic                      is_bdcst,
  output logic [NUM_CH-1:0]         overflow,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int unsigned PW = $clog2(fifo_depth);
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  logic [pckg_sz-1:0] mem_q    [NUM_CH][fifo_depth];
  logic [pckg_sz-1:0] pkt_in   [NUM_CH];
  logic [PW-1:0]      wr_ptr_q [NUM_CH];
  logic [PW-1:0]      wr_ptr_d [NUM_CH];
  logic [PW-1:0]      rd_ptr_q [NUM_CH];
  logic [PW-1:0]      rd_ptr_d [NUM_CH];
  logic [PW:0]        cnt_q    [NUM_CH];
  logic [PW:0]        cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]  ovf_q, ovf_d, wr_en, self_hit, pop_ch, avail;
  logic [CW-1:0]      grant_q, grant_d, rr_q, rr_d, start, sel;
  state_e             state_q, state_d;
  logic [pckg_sz-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [CNT_W+3:0]   drop_sum;
  logic               found;

  always_comb begin
    ovf_d    = ovf_q;
    drop_sum = {4'b0, drop_q};
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      pkt_in[c]   = data_in[c*pckg_sz +: pckg_sz];
      self_hit[c] = push[c] && (pkt_in[c][pckg_sz-9 -: 4] == self_row)
                            && (pkt_in[c][pckg_sz-13 -: 4] == self_col);
      pop_ch[c]   = (state_q == GRANT) && pop && (grant_q == CW'(c));
      full[c]     = (cnt_q[c] == (PW+1)'(fifo_depth));
      // a granted pop frees a slot in the same edge, so a full channel still accepts
      wr_en[c]    = push[c] && !self_hit[c] && (!full[c] || pop_ch[c]);
      ovf_d[c]    = ovf_q[c] | (push[c] && !self_hit[c] && full[c] && !pop_ch[c]);
      wr_ptr_d[c] = wr_ptr_q[c] + PW'(wr_en[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop_ch[c]);
      cnt_d[c]    = cnt_q[c] + (PW+1)'(wr_en[c]) - (PW+1)'(pop_ch[c]);
      drop_sum    = drop_sum + (CNT_W+4)'(self_hit[c]);
    end
    drop_d = (|drop_sum[CNT_W+3:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
  end

  // Arbitration sees the post-pop occupancy so a new grant can follow a pop with no bubble;
  // same-cycle pushes are deliberately not visible yet.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    dout_d  = dout_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      avail[c] = pop_ch[c] ? (cnt_q[c] > (PW+1)'(1)) : (cnt_q[c] != '0);
    end
    if (state_q == GRANT) begin
      start = (grant_q == CW'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
    end else begin
      start = rr_q;
    end
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      int unsigned idx;
      idx = int'(start) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && avail[CW'(idx)]) begin
        found = 1'b1;
        sel   = CW'(idx);
      end
    end
    if (state_q == GRANT && pop) begin
      rr_d    = start;
      state_d = IDLE;
    end
    if ((state_q == IDLE || pop) && found) begin
      state_d = GRANT;
      grant_d = sel;
      dout_d  = mem_q[sel][rd_ptr_d[sel]];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= pkt_in[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      ovf_q   <= '0;
      drop_q  <= '0;
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      dout_q  <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      dout_q  <= dout_d;
    end
  end

  assign pndng    = (state_q == GRANT);
  assign data_out = dout_q;
  assign is_bdcst = pndng && (dout_q[pckg_sz-19:0] == bdcst);
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mesh_term_inject_arb.sv
// Scoreboard bench for mesh_term_inject_arb: a queue-based reference model predicts grants,
// a negedge monitor compares every new presentation and the status outputs.
module tb_mesh_term_inject_arb;

  localparam int PK    = 40;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NCH-1:0]    push = '0;
  logic [NCH*PK-1:0] data_in = '0;
  logic [NCH-1:0]    full;
  logic              pndng;
  logic [PK-1:0]     data_out;
  logic              pop = 1'b0;
  logic              is_bdcst;
  logic [NCH-1:0]    overflow;
  logic [7:0]        drop_cnt;

  mesh_term_inject_arb #(
    .pckg_sz(PK), .fifo_depth(DEPTH), .NUM_CH(NCH),
    .self_row(4'd0), .self_col(4'd1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .full(full),
    .pndng(pndng), .data_out(data_out), .pop(pop), .is_bdcst(is_bdcst),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 0;

  // reference model state
  logic [PK-1:0] mq [NCH][$];
  logic [PK-1:0] exp_q [$];
  int            m_grant = -1;
  int            m_rr    = 0;
  int            m_drop  = 0;
  logic [NCH-1:0] m_ovf  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PK-1:0] mk(input int row, input int col, input logic [22:0] pl);
    logic [7:0] nj;
    nj = 8'($urandom_range(0, 255));
    return {nj, 4'(row), 4'(col), 1'b0, pl};
  endfunction

  function automatic bit is_self(input logic [PK-1:0] p);
    return (p[31:28] == 4'd0) && (p[27:24] == 4'd1);
  endfunction

  function automatic int pick(input int start);
    for (int i = 0; i < NCH; i++) begin
      int c;
      c = (start + i) % NCH;
      if (mq[c].size() != 0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    exp_q.delete();
    m_grant = -1;
    m_rr    = 0;
    m_drop  = 0;
    m_ovf   = '0;
  endtask

  // one clock edge of the abstract injector: serve the router, then accept the sources
  task automatic model_step(input logic [NCH-1:0] pv, input logic [NCH*PK-1:0] dv, input logic pp);
    if (m_grant >= 0 && pp) begin
      void'(mq[m_grant].pop_front());
      m_rr    = (m_grant + 1) % NCH;
      m_grant = -1;
    end
    if (m_grant < 0) begin
      m_grant = pick(m_rr);
      if (m_grant >= 0) exp_q.push_back(mq[m_grant][0]);
    end
    for (int c = 0; c < NCH; c++) begin
      logic [PK-1:0] p;
      p = dv[c*PK +: PK];
      if (pv[c]) begin
        if (is_self(p)) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else if (mq[c].size() < DEPTH) mq[c].push_back(p);
        else m_ovf[c] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic [NCH-1:0] p, input logic [PK-1:0] d0, input logic [PK-1:0] d1,
                       input logic pp);
    push    = p;
    data_in = {d1, d0};
    pop     = pp;
    @(posedge clk);
    model_step(push, data_in, pop);
    #1;
    push = '0;
    pop  = 1'b0;
  endtask

  // monitor
  initial begin
    bit prev_p;
    bit prev_t;
    prev_p = 0;
    prev_t = 0;
    forever begin
      @(negedge clk);
      if (!reset || !mon_en) begin
        prev_p = 0;
        prev_t = 0;
      end else begin
        logic [NCH-1:0] ef;
        logic           eb;
        for (int c = 0; c < NCH; c++) ef[c] = (mq[c].size() == DEPTH);
        eb = (m_grant >= 0) && (mq[m_grant][0][21:0] == 22'h3FFFFF);
        check("pndng", 64'(pndng), 64'(m_grant >= 0));
        check("full", 64'(full), 64'(ef));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        check("is_bdcst", 64'(is_bdcst), 64'(eb));
        if (pndng && (!prev_p || prev_t)) begin
          if (exp_q.size() == 0) check("unexpected_grant", 64'(1), 64'(0));
          else check("data_out", 64'(data_out), 64'(exp_q.pop_front()));
        end
        prev_p = pndng;
        prev_t = pndng && pop;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PK-1:0] pk, pa, pb, sp;
    model_reset();
    #12;
    check("rst_pndng", 64'(pndng), 64'(0));
    check("rst_full", 64'(full), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'(0));
    check("rst_is_bdcst", 64'(is_bdcst), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    mon_en = 1;

    // single packet latency
    pk = {8'h11, 4'd2, 4'd3, 1'b0, 23'h5};
    drive(2'b01, pk, '0, 1'b0);
    check("t1_pndng_push_cycle", 64'(pndng), 64'(0));
    drive(2'b00, '0, '0, 1'b0);
    check("t1_pndng", 64'(pndng), 64'(1));
    check("t1_data_out", 64'(data_out), 64'(pk));
    drive(2'b00, '0, '0, 1'b1);
    check("t1_pndng_after_pop", 64'(pndng), 64'(0));
    check("t1_full", 64'(full), 64'(0));

    // round robin, back to back
    for (int i = 0; i < 3; i++) drive(2'b11, mk(2, i, 23'(i)), mk(3, i, 23'(16 + i)), 1'b0);
    for (int i = 0; i < 8; i++) drive(2'b00, '0, '0, 1'b1);

    // overflow on ch1
    for (int i = 0; i < 5; i++) drive(2'b10, '0, mk(1, 2, 23'(32 + i)), 1'b0);
    check("t3_full1", 64'(full[1]), 64'(1));
    check("t3_overflow1", 64'(overflow[1]), 64'(1));
    for (int i = 0; i < 5; i++) drive(2'b00, '0, '0, 1'b1);
    #3 reset = 1'b0;
    #1 check("t3_overflow_reset", 64'(overflow), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;

    // self-address filter and saturation
    sp = mk(0, 1, 23'h7);
    drive(2'b11, sp, sp, 1'b0);
    check("t4_drop2", 64'(drop_cnt), 64'(2));
    for (int i = 0; i < 130; i++) drive(2'b11, sp, sp, 1'b0);
    check("t4_drop_sat", 64'(drop_cnt), 64'(255));
    drive(2'b00, '0, '0, 1'b0);
    check("t4_nothing_queued", 64'(pndng), 64'(0));

    // broadcast payload
    pb = {8'h22, 4'd1, 4'd1, 1'b1, 1'b0, 22'h3FFFFF};
    drive(2'b10, '0, pb, 1'b0);
    drive(2'b00, '0, '0, 1'b0);
    check("t5_is_bdcst", 64'(is_bdcst), 64'(1));
    drive(2'b00, '0, '0, 1'b1);
    check("t5_is_bdcst_after_pop", 64'(is_bdcst), 64'(0));

    // reset with a held grant
    pa = mk(3, 3, 23'h9);
    drive(2'b11, pa, mk(2, 2, 23'hA), 1'b0);
    drive(2'b01, mk(2, 0, 23'hB), '0, 1'b0);
    drive(2'b00, '0, '0, 1'b0);
    check("t6_grant_held", 64'(pndng), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("t6_pndng_async", 64'(pndng), 64'(0));
    check("t6_full_async", 64'(full), 64'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(2'b00, '0, '0, 1'b1);
    check("t6_empty_after_reset", 64'(pndng), 64'(0));

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [NCH-1:0] pv;
      logic [PK-1:0]  d [NCH];
      for (int c = 0; c < NCH; c++) begin
        logic [22:0] pl;
        pl   = ($urandom_range(0, 5) == 0) ? {1'b0, 22'h3FFFFF} : 23'($urandom);
        d[c] = mk($urandom_range(0, 1), $urandom_range(0, 3), pl);
      end
      pv = NCH'($urandom_range(0, 3));
      drive(pv, d[0], d[1], ($urandom_range(0, 9) < 6));
    end

    for (int i = 0; i < 40 && (m_grant >= 0 || mq[0].size() != 0 || mq[1].size() != 0); i++)
      drive(2'b00, '0, '0, 1'b1);
    check("drain_done", 64'(m_grant >= 0 || mq[0].size() != 0 || mq[1].size() != 0), 64'(0));
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mesh_term_inject_arb.md
Name: mesh_term_inject_arb

Overview:
- Synthesizable multi-channel packet injector for one mesh terminal; replaces the single per-terminal input FIFO with NUM_CH independent source channels.
- Each channel owns a circular packet FIFO; a round-robin arbiter presents one head packet to the router over the existing pndng/pop/data_out handshake.
- Adds self-address filtering, sticky per-channel overflow flags, a drop counter and a broadcast indication.

Parameters:
- pckg_sz, 40, packet width; header fields are nxt_jump[pckg_sz-1:pckg_sz-8], id_row[pckg_sz-9:pckg_sz-12], id_col[pckg_sz-13:pckg_sz-16], mode[pckg_sz-17]; payload is the remaining low bits.
- fifo_depth, 4, entries per channel (>=2, power of two).
- NUM_CH, 2, number of source channels (1..8).
- self_row, 0, terminal row coordinate.
- self_col, 1, terminal column coordinate.
- bdcst, {pckg_sz-18{1'b1}}, broadcast payload pattern in data[pckg_sz-19:0].
- CNT_W, 8, drop counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- push  in  NUM_CH  per-channel write strobe.
- data_in  in  NUM_CH*pckg_sz  channel c occupies bits [c*pckg_sz +: pckg_sz].
- full  out  NUM_CH  channel FIFO full.
- pndng  out  1  packet available to router.
- data_out  out  pckg_sz  granted head packet.
- pop  in  1  router consumes data_out.
- is_bdcst  out  1  data_out payload equals bdcst.
- overflow  out  NUM_CH  sticky, push while full.
- drop_cnt  out  CNT_W  self-addressed packets discarded, saturating.

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs empty, pointers 0, rr pointer 0, grant invalid, pndng=0, data_out=0, is_bdcst=0, full=0, overflow=0, drop_cnt=0.
- Push: on a rising edge with push[c]=1, the packet is written if the channel is not full. A write becomes visible to the arbiter on the next cycle (1-cycle latency from push to pndng).
- Self-filter: a pushed packet with id_row==self_row and id_col==self_col is not written. drop_cnt increments and saturates at all ones. Simultaneous self-addressed pushes on k channels add k in one cycle, still saturating.
- Overflow: push[c] while full[c]=1 and no same-cycle pop of c drops the packet and sets overflow[c]; the flag clears only on reset.
- A same-cycle push and granted pop on a full channel is accepted. The count stays at fifo_depth.
- full[c] is registered: count==fifo_depth.
- Arbiter FSM, states IDLE and GRANT:
  - IDLE: when any channel is non-empty, select the first non-empty channel starting at rr_ptr (ascending, wrapping), then go to GRANT. pndng=1 in the same cycle the grant registers.
  - GRANT: grant index and data_out stay frozen until pop. On pop, the head is removed, rr_ptr becomes grant+1 mod NUM_CH, and the next grant is evaluated combinationally. A back-to-back grant is allowed the cycle after pop (no bubble) if any channel is non-empty; otherwise go to IDLE with pndng=0.
- pop while pndng=0 is ignored.
- data_out is registered and updated only on a grant change. Its value is held after the final pop but is don't-care while pndng=0.
- is_bdcst is combinational from data_out, qualified by pndng.
- Pointer wrap: rd/wr pointers are log2(fifo_depth) bits and wrap naturally. Count is log2(fifo_depth)+1 bits.
- Reset mid-operation clears everything, including a frozen grant. pndng drops asynchronously.

Test Plan:
- Reset, then push ch0 with id_row=2, id_col=3, payload 0x5 -> pndng=1 one cycle after push, data_out equals the packet; pop -> pndng=0 next cycle, full=0.
- NUM_CH=2: push 3 packets on each channel at once, pop every cycle -> output order ch0,ch1,ch0,ch1,ch0,ch1 with no idle cycles; pndng falls after the 6th pop.
- Fill ch1 with 4 packets, then push a 5th -> full[1]=1, overflow[1]=1, 5th packet never appears; reset -> overflow=0.
- Push a packet with id_row=0, id_col=1 (self) on both channels in one cycle -> nothing queued, drop_cnt=2. Repeat until drop_cnt=255 -> holds 255.
- Push a packet whose payload equals bdcst -> is_bdcst=1 while granted, 0 after pop.
- Assert reset low with 3 packets queued and a grant held -> pndng=0, full=0 and the FIFOs empty immediately; after release, pndng=0 until a new push.
